run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/pc_next_calc.sv | 31 +++
 rtl/run_sequencer.sv | 122 ++++++++++++
 tb/tb_run_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default sizing for the run sequencer and its PC datapath.
// The run_state_t encoding is private to the sequencer FSM.
package cpu_pkg;

  localparam int PC_W_DEF    = 10;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    TOUT  = 3'd4
  } run_state_t;

  // Width of a select bus for n choices; a single choice still needs one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC datapath: sequential increment or sign-extended relative branch,
// with hold when the pipeline stalls or a halt freezes the PC.
module pc_next_calc #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8
) (
  input  logic [PC_W-1:0]  pc,
  input  logic             stall,
  input  logic             hold,
  input  logic             branch_take,
  input  logic [OFF_W-1:0] branch_off,
  output logic [PC_W-1:0]  pc_nxt
);

  logic signed [PC_W-1:0] off_ext;
  logic        [PC_W-1:0] pc_inc;

  // The offset is relative to the following instruction, so it is added on
  // top of pc+1; the sum wraps naturally at the PC width.
  assign off_ext = PC_W'($signed(branch_off));
  assign pc_inc  = pc + PC_W'(1);

  always_comb begin
    pc_nxt = pc;
    if (!stall && !hold) begin
      if (branch_take) pc_nxt = pc_inc + off_ext;
      else             pc_nxt = pc_inc;
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: arms on start, launches a program at a selected entry point,
// counts run cycles and reports completion either by halt or by cycle limit.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   ARMED | start seen, launch when start drops
//   RUN   | decoder enabled, PC and cycle counter advancing
//   DONE  | halted by done_i, ack high
//   TOUT  | cycle limit reached, ack and timeout high
module run_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int OFF_W   = 8,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int N_PROG  = 4,
  parameter logic [N_PROG-1:0][PC_W-1:0] PROG_BASE =
    {PC_W'(384), PC_W'(256), PC_W'(128), PC_W'(0)},
  localparam int SEL_W  = sel_w(N_PROG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  prog_sel,
  input  logic              stall,
  input  logic              done_i,
  input  logic              branch_take,
  input  logic [OFF_W-1:0]  branch_off,
  output logic [PC_W-1:0]   pc,
  output logic              run_en,
  output logic              ack,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  run_state_t        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              tout_q, tout_d;
  logic [PC_W-1:0]   base_addr;
  logic [PC_W-1:0]   pc_nxt;

  pc_next_calc #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_pc_next (
    .pc          (pc_q),
    .stall       (stall),
    .hold        (done_i),
    .branch_take (branch_take),
    .branch_off  (branch_off),
    .pc_nxt      (pc_nxt)
  );

  // Out-of-range selects fall back to the first entry point.
  always_comb begin
    base_addr = PROG_BASE[0];
    for (int i = 1; i < N_PROG; i++) begin
      if (prog_sel == SEL_W'(i)) base_addr = PROG_BASE[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = ARMED;
      end
      ARMED: begin
        if (!start) begin
          state_d = RUN;
          pc_d    = base_addr;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          cnt_d = cnt_q + CNT_W'(1);
          pc_d  = pc_nxt;
          // A halt in the limit cycle still counts as a normal finish.
          if (done_i)                state_d = DONE;
          else if (cnt_q == TO_LAST) state_d = TOUT;
        end
      end
      DONE, TOUT: begin
        if (start) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
    ack_d  = (state_d == DONE) || (state_d == TOUT);
    tout_d = (state_d == TOUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      tout_q  <= tout_d;
    end
  end

  assign pc          = pc_q;
  assign run_en      = (state_q == RUN);
  assign ack         = ack_q;
  assign timeout     = tout_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: vector table, hand-written corner sequences and a
// randomized run against a cycle-level reference of the launch/run/finish rules.
module tb_run_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall, done_i, branch_take;
  logic [1:0]  prog_sel;
  logic [7:0]  branch_off;
  logic [9:0]  pc;
  logic        run_en, ack, timeout;
  logic [15:0] cycle_count;

  logic [3:0]  pc_w;
  logic        run_en_w, ack_w, tout_w;
  logic [7:0]  cnt_w;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  run_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
    .stall(stall), .done_i(done_i), .branch_take(branch_take),
    .branch_off(branch_off), .pc(pc), .run_en(run_en), .ack(ack),
    .timeout(timeout), .cycle_count(cycle_count)
  );

  run_sequencer #(
    .PC_W(4), .OFF_W(4), .CNT_W(8), .TIMEOUT(64), .N_PROG(1), .PROG_BASE(4'd14)
  ) dut_w (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel[0]),
    .stall(stall), .done_i(done_i), .branch_take(branch_take),
    .branch_off(branch_off[3:0]), .pc(pc_w), .run_en(run_en_w), .ack(ack_w),
    .timeout(tout_w), .cycle_count(cnt_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] sel, input logic st,
                       input logic d, input logic t, input logic [7:0] o);
    start = s; prog_sel = sel; stall = st; done_i = d; branch_take = t; branch_off = o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic [1:0] sel;
    logic       stall;
    logic       done;
    logic       take;
    logic [7:0] off;
    int         pc;
    logic       run_en;
    logic       ack;
    logic       tout;
    int         cnt;
  } vec_t;

  vec_t tbl[15];

  // Reference model state: phase 0 idle, 1 armed, 2 run, 3 halted, 4 timed out.
  int m_phase, m_pc, m_cnt;
  int m_base[4] = '{0, 128, 256, 384};

  task automatic model_step();
    case (m_phase)
      0: if (start) m_phase = 1;
      1: if (!start) begin m_phase = 2; m_pc = m_base[prog_sel]; m_cnt = 0; end
      2: if (!stall) begin
           if (done_i) m_phase = 3;
           else begin
             m_pc = (m_pc + 1 + (branch_take ? int'($signed(branch_off)) : 0)) & 1023;
             if (m_cnt == 15) m_phase = 4;
           end
           m_cnt = m_cnt + 1;
         end
      default: if (start) m_phase = 1;
    endcase
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    chk("reset pc", pc, 0);
    chk("reset cnt", cycle_count, 0);
    chk("reset ack/to/run", {ack, timeout, run_en}, 0);
    @(negedge clk);
    reset = 1'b0;

    //          st sel stl dn tk off    pc  ren ack to cnt
    tbl[0]  = '{1, 0, 0, 0, 0, 8'h00,   0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 8'h00,   0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 8'h00, 128, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 8'h00, 129, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 0, 8'h00, 130, 1, 0, 0, 2};
    tbl[5]  = '{0, 0, 0, 0, 1, 8'h09, 140, 1, 0, 0, 3};
    tbl[6]  = '{0, 0, 0, 0, 1, 8'hFB, 136, 1, 0, 0, 4};
    tbl[7]  = '{0, 0, 0, 0, 1, 8'h03, 140, 1, 0, 0, 5};
    tbl[8]  = '{0, 0, 0, 0, 1, 8'h03, 144, 1, 0, 0, 6};
    tbl[9]  = '{0, 0, 1, 1, 1, 8'h03, 144, 1, 0, 0, 6};
    tbl[10] = '{1, 3, 0, 0, 0, 8'h00, 145, 1, 0, 0, 7};
    tbl[11] = '{0, 0, 0, 1, 1, 8'h03, 145, 0, 1, 0, 8};
    tbl[12] = '{0, 0, 0, 0, 0, 8'h00, 145, 0, 1, 0, 8};
    tbl[13] = '{1, 0, 0, 0, 0, 8'h00, 145, 0, 0, 0, 8};
    tbl[14] = '{0, 2, 0, 0, 0, 8'h00, 256, 1, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].start, tbl[i].sel, tbl[i].stall, tbl[i].done, tbl[i].take, tbl[i].off);
      tick();
      chk($sformatf("row%0d pc", i), pc, tbl[i].pc);
      chk($sformatf("row%0d run_en", i), run_en, tbl[i].run_en);
      chk($sformatf("row%0d ack", i), ack, tbl[i].ack);
      chk($sformatf("row%0d timeout", i), timeout, tbl[i].tout);
      chk($sformatf("row%0d cnt", i), cycle_count, tbl[i].cnt);
    end

    // Unstalled timeout: 16 run cycles from 256.
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++) tick();
    chk("tout15 ack", ack, 0);
    chk("tout15 run_en", run_en, 1);
    tick();
    chk("tout ack/to", {ack, timeout}, 2'b11);
    chk("tout cnt", cycle_count, 16);
    chk("tout pc", pc, 272);
    chk("tout run_en", run_en, 0);

    // Timeout with 5 stall cycles inserted: 21 cycles.
    drive(1, 0, 0, 0, 0, 0); tick();
    chk("relaunch ack drop", ack, 0);
    drive(0, 0, 0, 0, 0, 0); tick();
    for (int c = 1; c <= 20; c++) begin
      stall = (c % 3 == 0) && (c <= 15);
      done_i = stall;
      tick();
    end
    chk("stall20 ack", ack, 0);
    chk("stall20 cnt", cycle_count, 15);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("stall21 ack/to", {ack, timeout}, 2'b11);
    chk("stall21 pc", pc, 16);

    // Halt in the limit cycle wins over the timeout.
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 15; k++) tick();
    done_i = 1'b1; tick();
    chk("done16 ack/to", {ack, timeout}, 2'b10);
    chk("done16 cnt", cycle_count, 16);
    chk("done16 pc", pc, 15);

    // PC wrap on the 4-bit instance.
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("wrap pc0", pc_w, 14);
    chk("wrap run_en", run_en_w, 1);
    tick(); chk("wrap pc1", pc_w, 15);
    tick(); chk("wrap pc2", pc_w, 0);
    tick(); chk("wrap pc3", pc_w, 1);
    chk("wrap cnt", cnt_w, 3);
    chk("wrap ack/to", {ack_w, tout_w}, 0);

    // Asynchronous reset between edges.
    drive(1, 0, 0, 0, 0, 0);
    do_reset();
    tick();
    drive(0, 3, 0, 0, 0, 0); tick();
    chk("pre-rst pc", pc, 384);
    tick(); tick();
    #3 reset = 1'b1;
    #1;
    chk("async rst pc", pc, 0);
    chk("async rst flags", {ack, timeout, run_en}, 0);
    chk("async rst cnt", cycle_count, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0); tick();
    chk("post-rst launch pc", pc, 128);
    chk("post-rst run_en", run_en, 1);

    // Randomized run against the reference model.
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    m_phase = 0; m_pc = 0; m_cnt = 0;
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) < 3, 8'($urandom_range(0, 255)));
      model_step();
      tick();
      chk($sformatf("rand%0d", n), {3'b0, pc, run_en, ack, timeout, cycle_count},
          {3'b0, 10'(m_pc), m_phase == 2, m_phase >= 3, m_phase == 4, 16'(m_cnt)});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
